icache_refill_arbiter: RTL

- Shares one word-wide backing memory port between the instruction cache refill path (I-side, line read only) and the data cache (D-side, line read or line write-back).
- Sequences each granted request as an 8-beat word burst.
- Assembles read beats into a 256-bit line for the requester, or serialises a 256-bit write line onto the port.
- Sits between the instruction/data caches and the shared program/data memory.

---
 rtl/icache_refill_arbiter_pkg.sv | 19 +
 rtl/icache_refill_arbiter_rr.sv | 36 +++
 rtl/icache_refill_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/icache_refill_arbiter_pkg.sv
// Shared constants and types for the I/D cache refill arbiter.
// Line geometry, FSM state encoding and requester ids live here.
package icache_refill_arbiter_pkg;

    localparam int LINE_WORDS = 8;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = LINE_WORDS * WORD_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/icache_refill_arbiter_rr.sv
// Two-input round-robin arbiter producing a one-hot grant.
// The pointer only moves when both sides compete, so a lone requester never loses its turn.
module refill_rr_arbiter
    import icache_refill_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic ptr_q;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (&req) begin
                grant[ptr_q] = 1'b1;
            end else begin
                grant = req;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ_D;
        end else if (en && (&req)) begin
            ptr_q <= ~ptr_q;
        end
    end

endmodule

// File: rtl/icache_refill_arbiter.sv
// Shares one word-wide memory port between I-cache refills and D-cache line reads/writes,
// running each grant as a LINE_WORDS-beat burst with a per-beat ready timeout.
module icache_refill_arbiter
    import icache_refill_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = icache_refill_arbiter_pkg::LINE_WORDS,
    parameter int WORD_W     = icache_refill_arbiter_pkg::WORD_W,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_req,
    input  logic [31:0]                  i_addr,
    output logic [LINE_WORDS*WORD_W-1:0] i_line,
    output logic                         i_done,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [31:0]                  d_addr,
    input  logic [LINE_WORDS*WORD_W-1:0] d_wline,
    output logic [LINE_WORDS*WORD_W-1:0] d_rline,
    output logic                         d_done,
    output logic                         err,
    output logic [31:0]                  mem_addr,
    output logic                         mem_rd,
    output logic                         mem_wr,
    output logic [WORD_W-1:0]            mem_wdata,
    input  logic [WORD_W-1:0]            mem_rdata,
    input  logic                         mem_ready
);

    localparam int LINE_BITS = LINE_WORDS * WORD_W;
    localparam int BEAT_W    = $clog2(LINE_WORDS);
    localparam int BYTE_SH   = $clog2(WORD_W / 8);
    localparam int OFF_W     = BEAT_W + BYTE_SH;
    localparam int WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

    state_t               state, state_nxt;
    logic [1:0]           req_vec, grant;
    logic                 grant_d;
    logic [31:0]          sel_addr;
    logic                 addr_unused;
    logic [31:0]          base_q;
    logic                 id_q;
    logic                 err_q;
    logic [BEAT_W-1:0]    beat_q;
    logic [WAIT_W-1:0]    wait_q;
    logic [LINE_BITS-1:0] wline_q;
    logic                 timed_out;

    assign req_vec     = {d_req, i_req};
    assign grant_d     = grant[REQ_D];
    assign sel_addr    = grant_d ? d_addr : i_addr;
    assign addr_unused = ^sel_addr[OFF_W-1:0];
    assign timed_out   = !mem_ready && (wait_q == LAST_WAIT);

    refill_rr_arbiter u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_vec),
        .en    (state == IDLE),
        .grant (grant)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (|grant) state_nxt = (grant_d && d_we) ? WR_BURST : RD_BURST;
            end
            RD_BURST, WR_BURST: begin
                if ((mem_ready && beat_q == LAST_BEAT) || timed_out) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: line buffers are reset too, because the outputs must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            base_q  <= '0;
            id_q    <= REQ_I;
            err_q   <= 1'b0;
            beat_q  <= '0;
            wait_q  <= '0;
            wline_q <= '0;
            i_line  <= '0;
            d_rline <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        base_q <= {sel_addr[31:OFF_W], {OFF_W{1'b0}}};
                        id_q   <= grant_d;
                        err_q  <= 1'b0;
                        beat_q <= '0;
                        wait_q <= '0;
                        if (grant_d && d_we) wline_q <= d_wline;
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (mem_ready) begin
                        if (state == RD_BURST) begin
                            if (id_q == REQ_D) d_rline[beat_q*WORD_W +: WORD_W] <= mem_rdata;
                            else               i_line[beat_q*WORD_W +: WORD_W]  <= mem_rdata;
                        end
                        beat_q <= beat_q + 1'b1;
                        wait_q <= '0;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state register so reset drops them asynchronously.
    always_comb begin
        mem_rd    = (state == RD_BURST);
        mem_wr    = (state == WR_BURST);
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_rd || mem_wr) mem_addr = base_q | (32'(beat_q) << BYTE_SH);
        if (mem_wr) mem_wdata = wline_q[beat_q*WORD_W +: WORD_W];
        i_done = (state == DONE) && (id_q == REQ_I);
        d_done = (state == DONE) && (id_q == REQ_D);
        err    = (state == DONE) && err_q;
    end

endmodule
